// File: rtl/collatz_sequencer_pkg.sv
// Shared definitions for the Collatz sequencer: ALU opcodes, FSM state encoding,
// the largest odd value whose 3n+1 still fits the data path, and state decode helpers.
package collatz_sequencer_pkg;

    localparam logic [2:0] OP_SHR    = 3'b000;
    localparam logic [2:0] OP_TRIPLE = 3'b001;
    localparam logic [2:0] OP_DEC    = 3'b010;
    localparam logic [2:0] OP_LSB    = 3'b011;
    localparam logic [2:0] OP_PASS   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHKONE = 3'd1,
        ST_PARITY = 3'd2,
        ST_EVEN   = 3'd3,
        ST_ODD    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } seq_state_t;

    // Largest n for which 3n+1 is representable in 'width' bits.
    function automatic longint unsigned max_odd_f(input int unsigned width);
        return ((64'd1 << width) - 64'd2) / 64'd3;
    endfunction

    function automatic logic [2:0] state_opcode(input seq_state_t st);
        logic [2:0] op;
        case (st)
            ST_CHKONE: op = OP_DEC;
            ST_PARITY: op = OP_LSB;
            ST_EVEN:   op = OP_SHR;
            ST_ODD:    op = OP_TRIPLE;
            default:   op = OP_PASS;
        endcase
        return op;
    endfunction

    function automatic logic state_busy(input seq_state_t st);
        logic busy;
        case (st)
            ST_CHKONE, ST_PARITY, ST_EVEN, ST_ODD: busy = 1'b1;
            default:                               busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/collatz_sequencer_if.sv
// User/ALU-facing signal bundle of the Collatz sequencer.
// Optional COLLATZ_SEQ_PEAK_EN adds the peak-value output.
interface collatz_sequencer_if #(
    parameter int unsigned DATAWIDTH_BUS           = 8,
    parameter int unsigned DATAWIDTH_ALU_SELECTION = 3,
    parameter int unsigned DATAWIDTH_STEPS         = 8
);
    logic                               CC_SEQ_start_InLow;
    logic [DATAWIDTH_BUS-1:0]           CC_SEQ_seed_InBUS;
    logic [DATAWIDTH_BUS-1:0]           CC_SEQ_aluData_InBUS;
    logic                               CC_SEQ_aluZero_InLow;
    logic [DATAWIDTH_ALU_SELECTION-1:0] CC_SEQ_aluSelection_OutBUS;
    logic [DATAWIDTH_BUS-1:0]           CC_SEQ_aluDataA_OutBUS;
    logic [DATAWIDTH_STEPS-1:0]         CC_SEQ_steps_OutBUS;
    logic                               CC_SEQ_busy_Out;
    logic                               CC_SEQ_done_Out;
    logic                               CC_SEQ_error_Out;
`ifdef COLLATZ_SEQ_PEAK_EN
    logic [DATAWIDTH_BUS-1:0]           CC_SEQ_peak_OutBUS;
`endif

    // Sequencer side
    modport master (
        input  CC_SEQ_start_InLow, CC_SEQ_seed_InBUS, CC_SEQ_aluData_InBUS, CC_SEQ_aluZero_InLow,
`ifdef COLLATZ_SEQ_PEAK_EN
        output CC_SEQ_peak_OutBUS,
`endif
        output CC_SEQ_aluSelection_OutBUS, CC_SEQ_aluDataA_OutBUS, CC_SEQ_steps_OutBUS,
        output CC_SEQ_busy_Out, CC_SEQ_done_Out, CC_SEQ_error_Out
    );

    // User and ALU side
    modport slave (
        output CC_SEQ_start_InLow, CC_SEQ_seed_InBUS, CC_SEQ_aluData_InBUS, CC_SEQ_aluZero_InLow,
`ifdef COLLATZ_SEQ_PEAK_EN
        input  CC_SEQ_peak_OutBUS,
`endif
        input  CC_SEQ_aluSelection_OutBUS, CC_SEQ_aluDataA_OutBUS, CC_SEQ_steps_OutBUS,
        input  CC_SEQ_busy_Out, CC_SEQ_done_Out, CC_SEQ_error_Out
    );

endinterface

// File: rtl/collatz_sequencer_step_counter.sv
// Step counter with synchronous clear, enable and an all-ones flag; it never wraps,
// so the sequencer can flag an error instead of losing the count.
module collatz_sequencer_step_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, increment stops at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !at_max_o) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = &count_q;

endmodule

// File: rtl/collatz_sequencer.sv
// Collatz sequencer: drives an external combinational ALU to iterate n/2 or 3n+1 until n==1.
// Optional COLLATZ_SEQ_PEAK_EN tracks the largest value reached, seed included.
module collatz_sequencer
    import collatz_sequencer_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS           = 8,
    parameter int unsigned DATAWIDTH_ALU_SELECTION = 3,
    parameter int unsigned DATAWIDTH_STEPS         = 8
) (
    input  logic                 CC_SEQ_CLOCK_50,
    input  logic                 CC_SEQ_RESET_InLow,
    collatz_sequencer_if.master  seq_if
);

    localparam logic [DATAWIDTH_BUS-1:0] MAX_ODD = DATAWIDTH_BUS'(max_odd_f(DATAWIDTH_BUS));

    seq_state_t                         state_q;
    seq_state_t                         state_d;
    logic [DATAWIDTH_BUS-1:0]           value_q;
    logic [DATAWIDTH_BUS-1:0]           value_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0] sel_q;
    logic [DATAWIDTH_ALU_SELECTION-1:0] sel_d;
    logic                               busy_q;
    logic                               busy_d;
    logic                               done_q;
    logic                               done_d;
    logic                               error_q;
    logic                               error_d;
    logic [DATAWIDTH_STEPS-1:0]         steps_s;
    logic                               steps_max_s;
    logic                               start_s;
    logic                               accept_s;
    logic                               odd_ovf_s;
    logic                               value_we_s;

    assign start_s   = (state_q == ST_IDLE) && !seq_if.CC_SEQ_start_InLow;
    assign accept_s  = start_s && (seq_if.CC_SEQ_seed_InBUS != '0);
    assign odd_ovf_s = (value_q > MAX_ODD);

    collatz_sequencer_step_counter #(
        .WIDTH (DATAWIDTH_STEPS)
    ) u_step_counter (
        .clk_i    (CC_SEQ_CLOCK_50),
        .rst_n_i  (CC_SEQ_RESET_InLow),
        .clr_i    (start_s),
        .en_i     (value_we_s),
        .count_o  (steps_s),
        .at_max_o (steps_max_s)
    );

    // State register
    always_ff @(posedge CC_SEQ_CLOCK_50 or negedge CC_SEQ_RESET_InLow) begin
        if (!CC_SEQ_RESET_InLow) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ALU flags refer to the opcode decoded from the current state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_CHKONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHKONE: begin
                if (!seq_if.CC_SEQ_aluZero_InLow) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (!seq_if.CC_SEQ_aluZero_InLow) begin
                    state_d = ST_EVEN;
                end else begin
                    state_d = ST_ODD;
                end
            end
            ST_EVEN: begin
                if (steps_max_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_CHKONE;
                end
            end
            ST_ODD: begin
                if (odd_ovf_s || steps_max_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_CHKONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath decode
    always_comb begin
        sel_d      = DATAWIDTH_ALU_SELECTION'(state_opcode(state_d));
        busy_d     = state_busy(state_d);
        done_d     = (state_q == ST_DONE);
        value_we_s = 1'b0;
        case (state_q)
            ST_EVEN: value_we_s = !steps_max_s;
            ST_ODD:  value_we_s = !steps_max_s && !odd_ovf_s;
            default: value_we_s = 1'b0;
        endcase
        if (accept_s) begin
            value_d = seq_if.CC_SEQ_seed_InBUS;
        end else if (value_we_s) begin
            value_d = seq_if.CC_SEQ_aluData_InBUS;
        end else begin
            value_d = value_q;
        end
        // A zero seed can never reach 1, so it is rejected as an error
        if (accept_s) begin
            error_d = 1'b0;
        end else if (start_s || (state_q == ST_ERROR)) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Output and value registers
    always_ff @(posedge CC_SEQ_CLOCK_50 or negedge CC_SEQ_RESET_InLow) begin
        if (!CC_SEQ_RESET_InLow) begin
            value_q <= '0;
            sel_q   <= DATAWIDTH_ALU_SELECTION'(OP_PASS);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            value_q <= value_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef COLLATZ_SEQ_PEAK_EN
    logic [DATAWIDTH_BUS-1:0] peak_q;
    logic [DATAWIDTH_BUS-1:0] peak_d;

    // Peak follows every value write
    always_comb begin
        if (accept_s) begin
            peak_d = seq_if.CC_SEQ_seed_InBUS;
        end else if (value_we_s && (seq_if.CC_SEQ_aluData_InBUS > peak_q)) begin
            peak_d = seq_if.CC_SEQ_aluData_InBUS;
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register
    always_ff @(posedge CC_SEQ_CLOCK_50 or negedge CC_SEQ_RESET_InLow) begin
        if (!CC_SEQ_RESET_InLow) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign seq_if.CC_SEQ_peak_OutBUS = peak_q;
`endif

    assign seq_if.CC_SEQ_aluSelection_OutBUS = sel_q;
    assign seq_if.CC_SEQ_aluDataA_OutBUS     = value_q;
    assign seq_if.CC_SEQ_steps_OutBUS        = steps_s;
    assign seq_if.CC_SEQ_busy_Out            = busy_q;
    assign seq_if.CC_SEQ_done_Out            = done_q;
    assign seq_if.CC_SEQ_error_Out           = error_q;

endmodule

// File: tb/tb_collatz_sequencer.sv
// Self-checking bench for collatz_sequencer with a behavioural ALU and Collatz reference model.
module tb_collatz_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    collatz_sequencer_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_ALU_SELECTION(3), .DATAWIDTH_STEPS(8)) ifm ();
    collatz_sequencer_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_ALU_SELECTION(3), .DATAWIDTH_STEPS(3)) ifs ();

    collatz_sequencer #(.DATAWIDTH_BUS(8), .DATAWIDTH_ALU_SELECTION(3), .DATAWIDTH_STEPS(8)) u_dut (
        .CC_SEQ_CLOCK_50    (clk),
        .CC_SEQ_RESET_InLow (rst_n),
        .seq_if             (ifm)
    );

    collatz_sequencer #(.DATAWIDTH_BUS(8), .DATAWIDTH_ALU_SELECTION(3), .DATAWIDTH_STEPS(3)) u_dut_small (
        .CC_SEQ_CLOCK_50    (clk),
        .CC_SEQ_RESET_InLow (rst_n),
        .seq_if             (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a);
        case (sel)
            3'b000:  return a >> 1;
            3'b001:  return 8'((a * 8'd3) + 8'd1);
            3'b010:  return a - 8'd1;
            3'b011:  return a & 8'd1;
            3'b100:  return a;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        ifm.CC_SEQ_aluData_InBUS = alu_f(ifm.CC_SEQ_aluSelection_OutBUS, ifm.CC_SEQ_aluDataA_OutBUS);
        ifm.CC_SEQ_aluZero_InLow = (ifm.CC_SEQ_aluData_InBUS != 8'd0);
        ifs.CC_SEQ_aluData_InBUS = alu_f(ifs.CC_SEQ_aluSelection_OutBUS, ifs.CC_SEQ_aluDataA_OutBUS);
        ifs.CC_SEQ_aluZero_InLow = (ifs.CC_SEQ_aluData_InBUS != 8'd0);
    end

    // Collatz reference: plain arithmetic over the sequence, with 8-bit overflow and step cap
    function automatic void ref_model(input int seed, input int sw,
                                      output int steps, output bit err, output int peak);
        int n;
        int smax;
        n = seed; steps = 0; err = 1'b0; peak = seed; smax = (1 << sw) - 1;
        if (seed == 0) begin
            err = 1'b1;
            return;
        end
        while (n != 1 && !err) begin
            if (steps == smax) err = 1'b1;
            else if (n % 2 == 0) begin n = n / 2; steps++; end
            else if (n > (256 - 2) / 3) err = 1'b1;
            else begin
                n = 3 * n + 1; steps++;
                if (n > peak) peak = n;
            end
        end
    endfunction

    // Start a run on the main DUT and wait (bounded) for done or error.
    task automatic run_main(input logic [7:0] seed, output int lat, output bit got_done,
                            output bit got_err, output bit busy_seen);
        int k;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b0;
        ifm.CC_SEQ_seed_InBUS  = seed;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b1;
        k = 0;
        busy_seen = ifm.CC_SEQ_busy_Out;
        got_done  = ifm.CC_SEQ_done_Out;
        got_err   = ifm.CC_SEQ_error_Out;
        while (!got_done && !got_err && k < 1000) begin
            @(negedge clk);
            k++;
            busy_seen = busy_seen | ifm.CC_SEQ_busy_Out;
            got_done  = ifm.CC_SEQ_done_Out;
            got_err   = ifm.CC_SEQ_error_Out;
        end
        lat = k;
    endtask

    task automatic test_reset();
        checks++;
        if (ifm.CC_SEQ_aluSelection_OutBUS !== 3'b100 || ifm.CC_SEQ_busy_Out !== 1'b0 ||
            ifm.CC_SEQ_done_Out !== 1'b0 || ifm.CC_SEQ_error_Out !== 1'b0 ||
            ifm.CC_SEQ_steps_OutBUS !== 8'd0 || ifm.CC_SEQ_aluDataA_OutBUS !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: sel=%b busy=%b done=%b err=%b steps=%0d a=%0d, want 100 0 0 0 0 0",
                     ifm.CC_SEQ_aluSelection_OutBUS, ifm.CC_SEQ_busy_Out, ifm.CC_SEQ_done_Out,
                     ifm.CC_SEQ_error_Out, ifm.CC_SEQ_steps_OutBUS, ifm.CC_SEQ_aluDataA_OutBUS);
        end
`ifdef COLLATZ_SEQ_PEAK_EN
        checks++;
        if (ifm.CC_SEQ_peak_OutBUS !== 8'd0) begin
            errors++;
            $display("FAIL reset_peak: got %0d want 0", ifm.CC_SEQ_peak_OutBUS);
        end
`endif
    endtask

    task automatic test_directed();
        int seeds[5]  = '{1, 6, 7, 27, 0};
        int esteps[5] = '{0, 8, 16, 11, 0};
        bit eerr[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int epeak[5]  = '{1, 16, 52, 214, 0};
        int lat;
        bit gd, ge, bs;
        for (int i = 0; i < 5; i++) begin
            run_main(8'(seeds[i]), lat, gd, ge, bs);
            checks++;
            if (ifm.CC_SEQ_steps_OutBUS !== 8'(esteps[i]) || ge !== eerr[i] || gd !== !eerr[i]) begin
                errors++;
                $display("FAIL directed_seed%0d: steps=%0d done=%b err=%b want steps=%0d err=%b",
                         seeds[i], ifm.CC_SEQ_steps_OutBUS, gd, ge, esteps[i], eerr[i]);
            end
            checks++;
            if (bs !== (seeds[i] != 0)) begin
                errors++;
                $display("FAIL directed_busy_seed%0d: busy seen %b want %b", seeds[i], bs, seeds[i] != 0);
            end
            if (!eerr[i]) begin
                checks++;
                if (lat != 3 * esteps[i] + 2) begin
                    errors++;
                    $display("FAIL directed_latency_seed%0d: got %0d want %0d", seeds[i], lat, 3 * esteps[i] + 2);
                end
                @(negedge clk);
                checks++;
                if (ifm.CC_SEQ_done_Out !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_done_pulse_seed%0d: done still %b want 0", seeds[i], ifm.CC_SEQ_done_Out);
                end
            end
`ifdef COLLATZ_SEQ_PEAK_EN
            if (seeds[i] != 0) begin
                checks++;
                if (ifm.CC_SEQ_peak_OutBUS !== 8'(epeak[i])) begin
                    errors++;
                    $display("FAIL directed_peak_seed%0d: got %0d want %0d", seeds[i], ifm.CC_SEQ_peak_OutBUS, epeak[i]);
                end
            end
`else
            if (epeak[i] < 0) $display("unexpected peak table entry");
`endif
        end
    endtask

    task automatic test_sel_trace();
        logic [2:0] exp_sel[4] = '{3'b010, 3'b011, 3'b001, 3'b010};
        int lat;
        bit gd, ge, bs;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b0;
        ifm.CC_SEQ_seed_InBUS  = 8'd7;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ifm.CC_SEQ_aluSelection_OutBUS !== exp_sel[k]) begin
                errors++;
                $display("FAIL sel_trace[%0d]: got %b want %b", k, ifm.CC_SEQ_aluSelection_OutBUS, exp_sel[k]);
            end
            @(negedge clk);
        end
        lat = 0; gd = 1'b0; ge = 1'b0; bs = 1'b0;
        while (!ifm.CC_SEQ_done_Out && !ifm.CC_SEQ_error_Out && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (ifm.CC_SEQ_done_Out !== 1'b1 || ifm.CC_SEQ_steps_OutBUS !== 8'd16) begin
            errors++;
            $display("FAIL sel_trace_end: done=%b steps=%0d want 1 16", ifm.CC_SEQ_done_Out, ifm.CC_SEQ_steps_OutBUS);
        end
    endtask

    task automatic test_busy_ignore();
        int k;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b0;
        ifm.CC_SEQ_seed_InBUS  = 8'd6;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b1;
        repeat (5) @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b0;
        ifm.CC_SEQ_seed_InBUS  = 8'd27;
        repeat (2) @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b1;
        k = 7;
        while (!ifm.CC_SEQ_done_Out && !ifm.CC_SEQ_error_Out && k < 1000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ifm.CC_SEQ_done_Out !== 1'b1 || ifm.CC_SEQ_steps_OutBUS !== 8'd8 || k != 26) begin
            errors++;
            $display("FAIL busy_ignore: done=%b steps=%0d lat=%0d want 1 8 26",
                     ifm.CC_SEQ_done_Out, ifm.CC_SEQ_steps_OutBUS, k);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        int lat;
        bit gd, ge, bs;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b0;
        ifm.CC_SEQ_seed_InBUS  = 8'd7;
        @(negedge clk);
        ifm.CC_SEQ_start_InLow = 1'b1;
        k = 0;
        while (ifm.CC_SEQ_steps_OutBUS != 8'd5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifm.CC_SEQ_busy_Out !== 1'b0 || ifm.CC_SEQ_steps_OutBUS !== 8'd0 || ifm.CC_SEQ_done_Out !== 1'b0 ||
            ifm.CC_SEQ_aluDataA_OutBUS !== 8'd0 || ifm.CC_SEQ_aluSelection_OutBUS !== 3'b100 || k >= 200) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b steps=%0d done=%b a=%0d sel=%b wait=%0d want 0 0 0 0 100",
                     ifm.CC_SEQ_busy_Out, ifm.CC_SEQ_steps_OutBUS, ifm.CC_SEQ_done_Out,
                     ifm.CC_SEQ_aluDataA_OutBUS, ifm.CC_SEQ_aluSelection_OutBUS, k);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_main(8'd6, lat, gd, ge, bs);
        checks++;
        if (!gd || ge || ifm.CC_SEQ_steps_OutBUS !== 8'd8 || lat != 26) begin
            errors++;
            $display("FAIL after_reset_seed6: done=%b err=%b steps=%0d lat=%0d want 1 0 8 26",
                     gd, ge, ifm.CC_SEQ_steps_OutBUS, lat);
        end
    endtask

    task automatic test_step_saturation();
        int k;
        bit saw_done;
        @(negedge clk);
        ifs.CC_SEQ_start_InLow = 1'b0;
        ifs.CC_SEQ_seed_InBUS  = 8'd7;
        @(negedge clk);
        ifs.CC_SEQ_start_InLow = 1'b1;
        k = 0;
        saw_done = 1'b0;
        while (!ifs.CC_SEQ_error_Out && k < 500) begin
            @(negedge clk);
            k++;
            saw_done = saw_done | ifs.CC_SEQ_done_Out;
        end
        checks++;
        if (ifs.CC_SEQ_error_Out !== 1'b1 || ifs.CC_SEQ_steps_OutBUS !== 3'd7 || saw_done) begin
            errors++;
            $display("FAIL step_saturation: err=%b steps=%0d done_seen=%b want 1 7 0",
                     ifs.CC_SEQ_error_Out, ifs.CC_SEQ_steps_OutBUS, saw_done);
        end
    endtask

    task automatic test_random();
        int seed;
        int esteps;
        int epeak;
        bit eerr;
        int lat;
        bit gd, ge, bs;
        for (int i = 0; i < 24; i++) begin
            seed = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            ref_model(seed, 8, esteps, eerr, epeak);
            run_main(8'(seed), lat, gd, ge, bs);
            checks++;
            if (ge !== eerr || gd !== !eerr || bs !== (seed != 0) ||
                (seed != 0 && ifm.CC_SEQ_steps_OutBUS !== 8'(esteps)) ||
                (!eerr && lat != 3 * esteps + 2)) begin
                errors++;
                $display("FAIL random_seed%0d: done=%b err=%b busy=%b steps=%0d lat=%0d want err=%b steps=%0d lat=%0d",
                         seed, gd, ge, bs, ifm.CC_SEQ_steps_OutBUS, lat, eerr, esteps, 3 * esteps + 2);
            end
`ifdef COLLATZ_SEQ_PEAK_EN
            if (seed != 0) begin
                checks++;
                if (ifm.CC_SEQ_peak_OutBUS !== 8'(epeak)) begin
                    errors++;
                    $display("FAIL random_peak_seed%0d: got %0d want %0d", seed, ifm.CC_SEQ_peak_OutBUS, epeak);
                end
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifm.CC_SEQ_start_InLow = 1'b1;
        ifm.CC_SEQ_seed_InBUS  = 8'd0;
        ifs.CC_SEQ_start_InLow = 1'b1;
        ifs.CC_SEQ_seed_InBUS  = 8'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_directed();
        test_sel_trace();
        test_busy_ignore();
        test_reset_mid_run();
        test_step_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
